// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit encoding, packetizer FSM encoding and the
// bit offsets of the fields packed into a HEAD flit payload.
package noc_pkg;

    // Flit type encoding on the router link; the router decodes the same values.
    typedef enum logic [1:0] {
        FLIT_BODY = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_TAIL = 2'b10
    } flit_type_t;

    // Packetizer FSM encoding.
    typedef enum logic [1:0] {
        PKT_IDLE = 2'd0,
        PKT_HEAD = 2'd1,
        PKT_BODY = 2'd2
    } packetizer_state_t;

    // Width of one mesh coordinate; a 1-wide mesh still needs one bit.
    function automatic int coord_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // HEAD payload layout, LSB first: dst_x, dst_y, src_x, src_y, zeros.
    function automatic int head_dst_x_lsb();
        return 0;
    endfunction

    function automatic int head_dst_y_lsb(input int xw);
        return xw;
    endfunction

    function automatic int head_src_x_lsb(input int xw, input int yw);
        return xw + yw;
    endfunction

    function automatic int head_src_y_lsb(input int xw, input int yw);
        return 2 * xw + yw;
    endfunction

    // Number of payload bits the routing fields occupy.
    function automatic int head_used_w(input int xw, input int yw);
        return 2 * (xw + yw);
    endfunction

endpackage

// File: rtl/noc_packetizer_if.sv
// Processing-element message port plus router injection link of the packetizer.
// master = PE/router side, slave = packetizer side.
interface noc_packetizer_if #(
    parameter int XW        = 2,
    parameter int YW        = 2,
    parameter int DATA_W    = 32,
    parameter int MSG_WORDS = 4
);
    import noc_pkg::*;

    // Message handshake from the processing element.
    logic                        msg_valid;
    logic                        msg_ready;
    logic [XW-1:0]               msg_dst_x;
    logic [YW-1:0]               msg_dst_y;
    logic [MSG_WORDS*DATA_W-1:0] msg_data;

    // Flit stream into the router local input port.
    logic                        flit_valid;
    flit_type_t                  flit_type;
    logic [DATA_W-1:0]           flit_data;

    // Credit return and credit protocol error.
    logic                        credit_in;
    logic                        credit_err;

    modport master (
        output msg_valid, msg_dst_x, msg_dst_y, msg_data, credit_in,
        input  msg_ready, flit_valid, flit_type, flit_data, credit_err
    );

    modport slave (
        input  msg_valid, msg_dst_x, msg_dst_y, msg_data, credit_in,
        output msg_ready, flit_valid, flit_type, flit_data, credit_err
    );

endinterface

// File: rtl/noc_credit_counter.sv
// Credit counter for one link into a downstream buffer of CREDITS slots.
// Starts full, decrements per flit sent, increments per credit returned.
// A credit returned while already full is a protocol error: the count
// saturates and a sticky error flag is raised until reset.
module noc_credit_counter #(
    parameter int CREDITS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic send,
    input  logic credit_in,
    output logic has_credit,
    output logic err
);
    localparam int             CW   = $clog2(CREDITS + 1);
    localparam logic [CW-1:0]  FULL = CW'(CREDITS);

    logic [CW-1:0] count;
    logic          err_q;

    // Credit count and sticky overflow flag; send and return in the same cycle cancel.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop in
        // the design samples the pre-edge value of its inputs.
        if (rst) begin
            count <= FULL;
            err_q <= 1'b0;
        end else begin
            case ({send, credit_in})
                2'b10: count <= count - 1'b1;
                2'b01: begin
                    if (count == FULL) err_q <= 1'b1;
                    else               count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign has_credit = (count != '0);
    assign err        = err_q;

endmodule

// File: rtl/noc_packetizer.sv
// NoC injection stage: accepts one message (destination + MSG_WORDS words)
// per handshake and serialises it into HEAD, BODY..., TAIL flits toward the
// router's local input port, never sending without a credit.
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int SIZE_X    = 4,
    parameter int SIZE_Y    = 4,
    parameter int X_ID      = 0,
    parameter int Y_ID      = 0,
    parameter int DATA_W    = 32,   // must hold all four routing fields
    parameter int MSG_WORDS = 4,    // at least one data flit per packet
    parameter int CREDITS   = 4
) (
    input  logic             clk,
    input  logic             rst,
    noc_packetizer_if.slave  bus
);
    localparam int XW     = coord_w(SIZE_X);
    localparam int YW     = coord_w(SIZE_Y);
    localparam int IW     = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
    localparam int DY_LSB = head_dst_y_lsb(XW);
    localparam int SX_LSB = head_src_x_lsb(XW, YW);
    localparam int SY_LSB = head_src_y_lsb(XW, YW);

    localparam logic [1:0]    S_IDLE    = PKT_IDLE;
    localparam logic [1:0]    S_HEAD    = PKT_HEAD;
    localparam logic [1:0]    S_BODY    = PKT_BODY;
    localparam logic [IW-1:0] LAST_WORD = IW'(MSG_WORDS - 1);

    logic [1:0]                  state;
    logic [IW-1:0]               idx;
    logic [XW-1:0]               dst_x_q;
    logic [YW-1:0]               dst_y_q;
    logic [MSG_WORDS*DATA_W-1:0] data_q;
    logic [DATA_W-1:0]           head_word;

    logic                        flit_valid_q;
    flit_type_t                  flit_type_q;
    logic [DATA_W-1:0]           flit_data_q;

    logic                        ready;
    logic                        accept;
    logic                        has_credit;
    logic                        send;
    logic                        credit_err_w;

    // Only IDLE takes a message; held low while reset is applied.
    assign ready  = (state == S_IDLE) && !rst;
    assign accept = bus.msg_valid && ready;

    // A flit leaves in any emitting state that holds a credit.
    assign send = has_credit && ((state == S_HEAD) || (state == S_BODY));

    noc_credit_counter #(
        .CREDITS    (CREDITS)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .send       (send),
        .credit_in  (bus.credit_in),
        .has_credit (has_credit),
        .err        (credit_err_w)
    );

    // Assemble the HEAD payload from the captured destination and this node's id.
    always_comb begin
        // NOTE: the whole word gets a default first so no bit is left
        // unassigned on some path, which would infer a latch.
        head_word                 = '0;
        head_word[0 +: XW]        = dst_x_q;
        head_word[DY_LSB +: YW]   = dst_y_q;
        head_word[SX_LSB +: XW]   = XW'(X_ID);
        head_word[SY_LSB +: YW]   = YW'(Y_ID);
    end

    // Capture the offered message on handshake.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath storage, no reset: it is always written on
        // accept before anything reads it, so reset would only add fanout.
        if (accept) begin
            dst_x_q <= bus.msg_dst_x;
            dst_y_q <= bus.msg_dst_y;
            data_q  <= bus.msg_data;
        end
    end

    // Packet FSM and registered flit outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            flit_valid_q <= 1'b0;
            flit_type_q  <= FLIT_BODY;
            flit_data_q  <= '0;
        end else begin
            flit_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) state <= S_HEAD;
                end
                S_HEAD: begin
                    if (has_credit) begin
                        flit_valid_q <= 1'b1;
                        flit_type_q  <= FLIT_HEAD;
                        flit_data_q  <= head_word;
                        idx          <= '0;
                        state        <= S_BODY;
                    end
                end
                S_BODY: begin
                    if (has_credit) begin
                        flit_valid_q <= 1'b1;
                        flit_data_q  <= data_q[int'(idx)*DATA_W +: DATA_W];
                        if (idx == LAST_WORD) begin
                            flit_type_q <= FLIT_TAIL;
                            idx         <= '0;
                            state       <= S_IDLE;
                        end else begin
                            flit_type_q <= FLIT_BODY;
                            idx         <= idx + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.msg_ready  = ready;
    assign bus.flit_valid = flit_valid_q;
    assign bus.flit_type  = flit_type_q;
    assign bus.flit_data  = flit_data_q;
    assign bus.credit_err = credit_err_w;

endmodule

// File: tb/tb_noc_packetizer.sv
// Bench for noc_packetizer on a 4x4 mesh at node (1,2), 4 words/packet, 4 credits.
// Stimulus pushes expected flits into a queue; a monitor pops and compares.
module tb_noc_packetizer;
    import noc_pkg::*;

    localparam int SIZE_X    = 4;
    localparam int SIZE_Y    = 4;
    localparam int XW        = coord_w(SIZE_X);
    localparam int YW        = coord_w(SIZE_Y);
    localparam int DATA_W    = 32;
    localparam int MSG_WORDS = 4;
    localparam int CREDITS   = 4;

    typedef struct {
        flit_type_t        ftype;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    logic auto_ret;
    logic auto_pulse;
    logic man_pulse;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int flits_seen  = 0;
    int head_cyc    = 0;
    int tail_cyc    = 0;
    int head_gap    = 0;
    exp_t exp_q[$];

    noc_packetizer_if #(.XW(XW), .YW(YW), .DATA_W(DATA_W), .MSG_WORDS(MSG_WORDS)) bus ();

    noc_packetizer #(
        .SIZE_X(SIZE_X), .SIZE_Y(SIZE_Y), .X_ID(1), .Y_ID(2),
        .DATA_W(DATA_W), .MSG_WORDS(MSG_WORDS), .CREDITS(CREDITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.credit_in = auto_pulse | man_pulse;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Router model: returns one credit the cycle after each flit it received.
    initial begin
        logic v;
        auto_pulse = 1'b0;
        forever begin
            @(negedge clk);
            v = bus.flit_valid;
            @(posedge clk);
            #1 auto_pulse = auto_ret && v;
        end
    end

    // Monitor: compare every presented flit against the head of the queue.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (bus.flit_valid === 1'b1) begin
            flits_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_flit", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("flit_type", 64'(bus.flit_type), 64'(e.ftype));
                check("flit_data", 64'(bus.flit_data), 64'(e.data));
            end
            if (bus.flit_type == FLIT_HEAD) begin
                head_gap = cyc - tail_cyc;
                head_cyc = cyc;
            end
            if (bus.flit_type == FLIT_TAIL) tail_cyc = cyc;
        end
    end

    // Offer a message, wait (bounded) for the handshake, queue its flits.
    task automatic send_msg(input logic [XW-1:0] dx, input logic [YW-1:0] dy,
                            input logic [DATA_W-1:0] head, input logic [DATA_W-1:0] w0,
                            output int acc);
        exp_t e;
        bus.msg_valid = 1'b1;
        bus.msg_dst_x = dx;
        bus.msg_dst_y = dy;
        for (int i = 0; i < MSG_WORDS; i++) bus.msg_data[i*DATA_W +: DATA_W] = w0 + DATA_W'(i);
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus.msg_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (acc < 0) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            e.ftype = FLIT_HEAD;
            e.data  = head;
            exp_q.push_back(e);
            for (int i = 0; i < MSG_WORDS; i++) begin
                e.ftype = (i == MSG_WORDS - 1) ? FLIT_TAIL : FLIT_BODY;
                e.data  = w0 + DATA_W'(i);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1 bus.msg_valid = 1'b0;
    endtask

    task automatic wait_flits(input int n, input string name);
        bool_wait: begin
            for (int i = 0; i < 200; i++) begin
                if (flits_seen >= n) disable bool_wait;
                @(negedge clk);
                #1;
            end
            check(name, 64'(flits_seen), 64'(n));
        end
    endtask

    task automatic pulse_credit(output int k);
        man_pulse = 1'b1;
        k = cyc;
        @(negedge clk);
        #1 man_pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int acc, base, k, rc;
        rst           = 1'b1;
        auto_ret      = 1'b0;
        man_pulse     = 1'b0;
        bus.msg_valid = 1'b0;
        bus.msg_dst_x = '0;
        bus.msg_dst_y = '0;
        bus.msg_data  = '0;

        // Reset state.
        idle(2);
        check("rst_flit_valid", 64'(bus.flit_valid), 64'd0);
        check("rst_msg_ready", 64'(bus.msg_ready), 64'd0);
        check("rst_credit_err", 64'(bus.credit_err), 64'd0);
        check("rst_flit_type", 64'(bus.flit_type), 64'(FLIT_BODY));
        check("rst_flit_data", 64'(bus.flit_data), 64'd0);
        rst = 1'b0;
        idle(1);
        check("idle_msg_ready", 64'(bus.msg_ready), 64'd1);

        // Message A with credits returned behind each flit: no stalls.
        auto_ret = 1'b1;
        base = flits_seen;
        send_msg(2'd3, 2'd0, 32'h93, 32'hA0, acc);
        wait_flits(base + 5, "a_flits_timeout");
        check("a_back_to_back", 64'(tail_cyc - head_cyc), 64'(MSG_WORDS));
        rc = -1;
        for (int i = 0; i < 50; i++) begin
            if (bus.msg_ready === 1'b1) begin
                rc = cyc;
                break;
            end
            idle(1);
        end
        check("a_ready_return", 64'(rc - acc), 64'(MSG_WORDS + 2));
        idle(3);
        auto_ret = 1'b0;

        // Same message without credit return: stall before TAIL.
        base = flits_seen;
        send_msg(2'd3, 2'd0, 32'h93, 32'hA0, acc);
        wait_flits(base + 4, "nocred_flits_timeout");
        idle(3);
        check("nocred_stall_count", 64'(flits_seen - base), 64'd4);
        check("nocred_stall_valid", 64'(bus.flit_valid), 64'd0);
        pulse_credit(k);
        wait_flits(base + 5, "nocred_tail_timeout");
        check("nocred_tail_after_credit", 64'(tail_cyc - k), 64'd2);
        // Counter is now empty: four returns must not overflow.
        repeat (4) begin
            pulse_credit(k);
            idle(1);
        end
        check("refill_no_err", 64'(bus.credit_err), 64'd0);

        // Credit returned on the same edge as the HEAD send: count stays full.
        base = flits_seen;
        send_msg(2'd2, 2'd3, 32'h9E, 32'hD0, acc);
        man_pulse = 1'b1;
        @(posedge clk);
        #1 man_pulse = 1'b0;
        wait_flits(base + 5, "overlap_flits_timeout");
        check("overlap_back_to_back", 64'(tail_cyc - head_cyc), 64'(MSG_WORDS));
        repeat (4) begin
            pulse_credit(k);
            idle(1);
        end
        check("overlap_refill_no_err", 64'(bus.credit_err), 64'd0);
        pulse_credit(k);
        check("overlap_overflow_err", 64'(bus.credit_err), 64'd1);

        // Overflow straight after reset, sticky until the next reset.
        rst = 1'b1;
        idle(1);
        check("rst2_credit_err", 64'(bus.credit_err), 64'd0);
        check("rst2_msg_ready", 64'(bus.msg_ready), 64'd0);
        rst = 1'b0;
        idle(1);
        check("full_no_err", 64'(bus.credit_err), 64'd0);
        pulse_credit(k);
        check("full_overflow_err", 64'(bus.credit_err), 64'd1);
        idle(5);
        check("err_sticky", 64'(bus.credit_err), 64'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("err_cleared_by_rst", 64'(bus.credit_err), 64'd0);
        idle(1);

        // Message B held while A is in flight.
        auto_ret = 1'b1;
        base = flits_seen;
        send_msg(2'd3, 2'd0, 32'h93, 32'hA0, acc);
        send_msg(2'd0, 2'd1, 32'h94, 32'hB0, acc);
        wait_flits(base + 10, "ab_flits_timeout");
        check("b_head_after_a_tail", 64'(head_gap), 64'd2);
        idle(3);

        // Reset after the second body flit abandons the packet (E addressed to self).
        base = flits_seen;
        send_msg(2'd1, 2'd2, 32'h99, 32'hE0, acc);
        wait_flits(base + 3, "e_flits_timeout");
        rst      = 1'b1;
        auto_ret = 1'b0;
        exp_q.delete();
        idle(1);
        check("midrst_flit_valid", 64'(bus.flit_valid), 64'd0);
        check("midrst_credit_err", 64'(bus.credit_err), 64'd0);
        rst = 1'b0;
        idle(2);
        check("midrst_no_tail", 64'(flits_seen - base), 64'd3);

        // Fresh packet after reset: exactly CREDITS flits before the stall.
        base = flits_seen;
        send_msg(2'd0, 2'd0, 32'h90, 32'hF0, acc);
        wait_flits(base + 4, "f_flits_timeout");
        idle(3);
        check("f_credits_restored", 64'(flits_seen - base), 64'(CREDITS));
        pulse_credit(k);
        wait_flits(base + 5, "f_tail_timeout");
        idle(2);
        check("f_no_err", 64'(bus.credit_err), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
